// File: rtl/fifo_v3_core.sv
// Purpose : generic synchronous FIFO storage with full/empty/usage flags, flush and optional fall-through.
// Latency : 1 cycle push-to-head (0 cycles into an empty FIFO when FALL_THROUGH=1); DEPTH=0 is pure wire.
// Backpr. : push dropped while full_o, pop ignored while empty_o; define FIFO_V3_ASSERTS_EN for sim checks.
module fifo_v3_core #(
   parameter bit          FALL_THROUGH = 1'b0,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned DEPTH        = 8,
   parameter type         dtype        = logic [DATA_WIDTH-1:0],
   parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  flush_i,
   input  logic                  testmode_i,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [ADDR_DEPTH-1:0] usage_o,
   input  dtype                  data_i,
   input  logic                  push_i,
   output dtype                  data_o,
   input  logic                  pop_i
);

   // Storage is always at least one entry so the array is legal even when unused.
   localparam int unsigned           STORE_DEPTH = (DEPTH > 0) ? DEPTH : 1;
   localparam logic [ADDR_DEPTH-1:0] LAST_PTR    = ADDR_DEPTH'(STORE_DEPTH - 1);
   localparam logic [ADDR_DEPTH:0]   FULL_CNT    = (ADDR_DEPTH + 1)'(DEPTH);

   // Clock-gate bypass has no functional meaning for flop-based storage.
   logic w_unused_testmode;
   assign w_unused_testmode = testmode_i;

   if (DEPTH == 0) begin : g_passthru
      // No storage: the consumer sees the producer directly.
      logic w_unused_pt;
      assign w_unused_pt = ^{clk_i, rst_ni, flush_i};

      assign data_o  = data_i;
      assign empty_o = !push_i;
      assign full_o  = !pop_i;
      assign usage_o = '0;
   end else begin : g_fifo
      logic [ADDR_DEPTH-1:0] r_rptr;
      logic [ADDR_DEPTH-1:0] r_wptr;
      logic [ADDR_DEPTH:0]   r_count;
      dtype                  r_mem [STORE_DEPTH];

      logic w_full;
      logic w_empty;
      logic w_ft_bypass;
      logic w_push_en;
      logic w_pop_en;

      // Flags and effective push/pop qualification.
      always_comb begin
         w_full      = (r_count == FULL_CNT);
         w_empty     = (r_count == '0) && !(FALL_THROUGH && push_i);
         // Empty FIFO in fall-through mode forwards the incoming word directly.
         w_ft_bypass = FALL_THROUGH && push_i && (r_count == '0);
         // A bypassed word that is consumed in the same cycle is never stored.
         w_push_en   = push_i && !w_full && !(w_ft_bypass && pop_i);
         w_pop_en    = pop_i && !w_empty && !w_ft_bypass;
      end

      // Pointer and count bookkeeping; flush beats any concurrent push/pop.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
         end else if (flush_i) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
         end else begin
            // Explicit wrap keeps non-power-of-2 depths correct.
            if (w_push_en) begin
               r_wptr <= (r_wptr == LAST_PTR) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop_en) begin
               r_rptr <= (r_rptr == LAST_PTR) ? '0 : r_rptr + 1'b1;
            end
            case ({w_push_en, w_pop_en})
               2'b10:   r_count <= r_count + 1'b1;
               2'b01:   r_count <= r_count - 1'b1;
               default: r_count <= r_count;
            endcase
         end
      end

      // Storage write; entries start at zero so data_o is defined out of reset.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            for (int i = 0; i < int'(STORE_DEPTH); i++) begin
               r_mem[i] <= '0;
            end
         end else if (w_push_en && !flush_i) begin
            r_mem[r_wptr] <= data_i;
         end
      end

      assign full_o  = w_full;
      assign empty_o = w_empty;
      // Truncation at power-of-2 full is intentional; full_o disambiguates.
      assign usage_o = r_count[ADDR_DEPTH-1:0];
      assign data_o  = w_ft_bypass ? data_i : r_mem[r_rptr];
   end

`ifdef FIFO_V3_ASSERTS_EN
   // Pointer width must stay tied to DEPTH; a pass-through FIFO reports no usage.
   if (ADDR_DEPTH != ((DEPTH > 1) ? $clog2(DEPTH) : 1)) begin : g_chk_addr
      $error("fifo_v3_core: ADDR_DEPTH must not be overridden");
   end

   // Flag producer misuse: pushing into a full or popping an empty FIFO.
   always @(posedge clk_i) begin
      if (rst_ni && (DEPTH > 0)) begin
         assert (!(push_i && full_o)) else $error("fifo_v3_core: push while full");
         assert (!(pop_i && empty_o)) else $error("fifo_v3_core: pop while empty");
      end
   end
`endif

endmodule

// File: tb/tb_fifo_v3_core.sv
module tb_fifo_v3_core;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // DEPTH=8 normal mode
   logic       d8_flush = 0, d8_push = 0, d8_pop = 0;
   logic [7:0] d8_din = 0, d8_dout;
   logic       d8_full, d8_empty;
   logic [2:0] d8_usage;
   // DEPTH=3 normal mode
   logic       d3_flush = 0, d3_push = 0, d3_pop = 0;
   logic [7:0] d3_din = 0, d3_dout;
   logic       d3_full, d3_empty;
   logic [1:0] d3_usage;
   // DEPTH=4 fall-through
   logic       ft_flush = 0, ft_push = 0, ft_pop = 0;
   logic [7:0] ft_din = 0, ft_dout;
   logic       ft_full, ft_empty;
   logic [1:0] ft_usage;
   // DEPTH=0 pass-through
   logic       d0_flush = 0, d0_push = 0, d0_pop = 0;
   logic [7:0] d0_din = 0, d0_dout;
   logic       d0_full, d0_empty;
   logic       d0_usage;

   fifo_v3_core #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(8)) u_d8 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(d8_flush), .testmode_i(1'b0),
      .full_o(d8_full), .empty_o(d8_empty), .usage_o(d8_usage),
      .data_i(d8_din), .push_i(d8_push), .data_o(d8_dout), .pop_i(d8_pop));

   fifo_v3_core #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(3)) u_d3 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(d3_flush), .testmode_i(1'b0),
      .full_o(d3_full), .empty_o(d3_empty), .usage_o(d3_usage),
      .data_i(d3_din), .push_i(d3_push), .data_o(d3_dout), .pop_i(d3_pop));

   fifo_v3_core #(.FALL_THROUGH(1'b1), .DATA_WIDTH(8), .DEPTH(4)) u_ft (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(ft_flush), .testmode_i(1'b0),
      .full_o(ft_full), .empty_o(ft_empty), .usage_o(ft_usage),
      .data_i(ft_din), .push_i(ft_push), .data_o(ft_dout), .pop_i(ft_pop));

   fifo_v3_core #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(0)) u_d0 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(d0_flush), .testmode_i(1'b0),
      .full_o(d0_full), .empty_o(d0_empty), .usage_o(d0_usage),
      .data_i(d0_din), .push_i(d0_push), .data_o(d0_dout), .pop_i(d0_pop));

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (d8_empty !== 1'b1) begin n_err++; $display("FAIL reset_d8_empty got %b exp 1", d8_empty); end
      n_cmp++; if (d8_full !== 1'b0) begin n_err++; $display("FAIL reset_d8_full got %b exp 0", d8_full); end
      n_cmp++; if (d8_usage !== 3'd0) begin n_err++; $display("FAIL reset_d8_usage got %0d exp 0", d8_usage); end
      n_cmp++; if (d8_dout !== 8'h00) begin n_err++; $display("FAIL reset_d8_data got %h exp 00", d8_dout); end
      n_cmp++; if (d3_empty !== 1'b1 || d3_usage !== 2'd0) begin n_err++; $display("FAIL reset_d3 got empty %b usage %0d exp 1/0", d3_empty, d3_usage); end
      n_cmp++; if (ft_empty !== 1'b1 || ft_full !== 1'b0) begin n_err++; $display("FAIL reset_ft got empty %b full %b exp 1/0", ft_empty, ft_full); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      n_cmp++; if (d8_empty !== 1'b1 || d8_usage !== 3'd0) begin n_err++; $display("FAIL idle_d8 got empty %b usage %0d exp 1/0", d8_empty, d8_usage); end
   endtask

   task automatic test_fill_drain_d8();
      logic [2:0] eu;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         d8_push = 1'b1; d8_din = 8'(i);
         @(posedge clk);
         #1;
         eu = 3'(i + 1);
         n_cmp++; if (d8_usage !== eu) begin n_err++; $display("FAIL fill_usage[%0d] got %0d exp %0d", i, d8_usage, eu); end
         n_cmp++; if (d8_full !== (i == 7)) begin n_err++; $display("FAIL fill_full[%0d] got %b exp %b", i, d8_full, (i == 7)); end
         n_cmp++; if (d8_empty !== 1'b0) begin n_err++; $display("FAIL fill_empty[%0d] got %b exp 0", i, d8_empty); end
      end
      // Ninth push while full must be dropped.
      @(negedge clk);
      d8_din = 8'hFF;
      @(posedge clk);
      #1;
      d8_push = 1'b0;
      n_cmp++; if (d8_full !== 1'b1 || d8_usage !== 3'd0) begin n_err++; $display("FAIL overflow got full %b usage %0d exp 1/0", d8_full, d8_usage); end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         d8_pop = 1'b1;
         #1;
         n_cmp++; if (d8_dout !== 8'(i)) begin n_err++; $display("FAIL drain_data[%0d] got %h exp %h", i, d8_dout, 8'(i)); end
         @(posedge clk);
      end
      @(negedge clk);
      d8_pop = 1'b0;
      #1;
      n_cmp++; if (d8_empty !== 1'b1 || d8_full !== 1'b0 || d8_usage !== 3'd0) begin n_err++; $display("FAIL drained got empty %b full %b usage %0d exp 1/0/0", d8_empty, d8_full, d8_usage); end
      // Pop on an empty FIFO is ignored.
      @(negedge clk);
      d8_pop = 1'b1;
      @(posedge clk);
      #1;
      d8_pop = 1'b0;
      n_cmp++; if (d8_empty !== 1'b1 || d8_usage !== 3'd0) begin n_err++; $display("FAIL underflow got empty %b usage %0d exp 1/0", d8_empty, d8_usage); end
   endtask

   task automatic test_wrap_d3();
      logic       tp [10] = '{1, 1, 1, 1, 1, 1, 0, 1, 0, 0};
      logic       tq [10] = '{0, 0, 1, 1, 1, 0, 1, 1, 1, 1};
      logic [7:0] q[$];
      logic       pe, ue;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         d3_push = tp[i]; d3_pop = tq[i]; d3_din = 8'(8'h30 + i);
         #1;
         if (tq[i] && q.size() > 0) begin
            n_cmp++; if (d3_dout !== q[0]) begin n_err++; $display("FAIL wrap_data[%0d] got %h exp %h", i, d3_dout, q[0]); end
         end
         pe = tq[i] && (q.size() > 0);
         ue = tp[i] && (q.size() < 3);
         @(posedge clk);
         if (pe) void'(q.pop_front());
         if (ue) q.push_back(8'(8'h30 + i));
         #1;
         n_cmp++; if (d3_usage !== 2'(q.size()) || d3_full !== (q.size() == 3)) begin n_err++; $display("FAIL wrap_usage[%0d] got %0d full %b exp %0d", i, d3_usage, d3_full, q.size()); end
      end
      @(negedge clk);
      d3_push = 1'b0; d3_pop = 1'b0;
      #1;
      n_cmp++; if (d3_empty !== 1'b1) begin n_err++; $display("FAIL wrap_end_empty got %b exp 1", d3_empty); end
   endtask

   task automatic test_fall_through();
      @(negedge clk);
      ft_push = 1'b1; ft_pop = 1'b1; ft_din = 8'hA5;
      #1;
      n_cmp++; if (ft_dout !== 8'hA5) begin n_err++; $display("FAIL ft_bypass_data got %h exp a5", ft_dout); end
      n_cmp++; if (ft_empty !== 1'b0) begin n_err++; $display("FAIL ft_bypass_empty got %b exp 0", ft_empty); end
      @(posedge clk);
      #1;
      ft_push = 1'b0; ft_pop = 1'b0;
      #1;
      n_cmp++; if (ft_empty !== 1'b1 || ft_usage !== 2'd0) begin n_err++; $display("FAIL ft_after_bypass got empty %b usage %0d exp 1/0", ft_empty, ft_usage); end
      // Push without pop into an empty FIFO: visible now and stored.
      @(negedge clk);
      ft_push = 1'b1; ft_din = 8'hB6;
      #1;
      n_cmp++; if (ft_dout !== 8'hB6) begin n_err++; $display("FAIL ft_push_data got %h exp b6", ft_dout); end
      @(posedge clk);
      #1;
      ft_push = 1'b0; ft_din = 8'h00;
      #1;
      n_cmp++; if (ft_usage !== 2'd1 || ft_empty !== 1'b0 || ft_dout !== 8'hB6) begin n_err++; $display("FAIL ft_stored got usage %0d empty %b data %h exp 1/0/b6", ft_usage, ft_empty, ft_dout); end
      @(negedge clk);
      ft_pop = 1'b1;
      @(posedge clk);
      #1;
      ft_pop = 1'b0;
      #1;
      n_cmp++; if (ft_empty !== 1'b1) begin n_err++; $display("FAIL ft_popped_empty got %b exp 1", ft_empty); end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         d8_push = 1'b1; d8_din = 8'(8'h40 + i);
         @(posedge clk);
      end
      #1;
      n_cmp++; if (d8_usage !== 3'd5) begin n_err++; $display("FAIL flush_prefill got %0d exp 5", d8_usage); end
      @(negedge clk);
      d8_flush = 1'b1; d8_din = 8'h77;
      @(posedge clk);
      #1;
      d8_flush = 1'b0; d8_push = 1'b0;
      #1;
      n_cmp++; if (d8_usage !== 3'd0 || d8_empty !== 1'b1) begin n_err++; $display("FAIL flush got usage %0d empty %b exp 0/1", d8_usage, d8_empty); end
      @(negedge clk);
      d8_push = 1'b1; d8_din = 8'h55;
      @(posedge clk);
      #1;
      d8_push = 1'b0;
      #1;
      n_cmp++; if (d8_dout !== 8'h55 || d8_usage !== 3'd1) begin n_err++; $display("FAIL post_flush got data %h usage %0d exp 55/1", d8_dout, d8_usage); end
      @(negedge clk);
      d8_pop = 1'b1;
      @(posedge clk);
      #1;
      d8_pop = 1'b0;
   endtask

   task automatic test_passthrough();
      @(negedge clk);
      d0_push = 1'b1; d0_pop = 1'b1; d0_din = 8'h12;
      #1;
      n_cmp++; if (d0_dout !== 8'h12) begin n_err++; $display("FAIL pt_data got %h exp 12", d0_dout); end
      n_cmp++; if (d0_empty !== 1'b0 || d0_full !== 1'b0 || d0_usage !== 1'b0) begin n_err++; $display("FAIL pt_flags got empty %b full %b usage %b exp 0/0/0", d0_empty, d0_full, d0_usage); end
      d0_pop = 1'b0;
      #1;
      n_cmp++; if (d0_full !== 1'b1) begin n_err++; $display("FAIL pt_full got %b exp 1", d0_full); end
      d0_push = 1'b0;
      #1;
      n_cmp++; if (d0_empty !== 1'b1) begin n_err++; $display("FAIL pt_empty got %b exp 1", d0_empty); end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         d3_push = 1'b1; d3_din = 8'(8'h61 + i);
         @(posedge clk);
      end
      @(negedge clk);
      d3_push = 1'b0;
      #1;
      n_cmp++; if (d3_usage !== 2'd2) begin n_err++; $display("FAIL arst_prefill got %0d exp 2", d3_usage); end
      rst_n = 1'b0;
      #1;
      n_cmp++; if (d3_usage !== 2'd0 || d3_empty !== 1'b1 || d3_dout !== 8'h00) begin n_err++; $display("FAIL arst_d3 got usage %0d empty %b data %h exp 0/1/00", d3_usage, d3_empty, d3_dout); end
      n_cmp++; if (d8_dout !== 8'h00) begin n_err++; $display("FAIL arst_d8_data got %h exp 00", d8_dout); end
      #1;
      rst_n = 1'b1;
      @(posedge clk);
   endtask

   initial begin
      test_reset();
      test_fill_drain_d8();
      test_wrap_d3();
      test_fall_through();
      test_flush();
      test_passthrough();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
